seg_shift_receiver: RTL and testbench

- Receive end of the serial display link that `segment_scan` drives (`seg_sck` / `seg_din` / `seg_rck`).
- Behaves as a cycle-accurate 74HC595-pair model in the system clock domain: deserialises 16-bit frames, latches them on `seg_rck`, and decodes digit-select plus segment pattern into an 8-digit shadow of the display.
- Used as a loopback checker on the board debug path and as the display monitor in `plan_b` system benches.

---
 rtl/seg_link_pkg.sv | 13 +
 rtl/seg_shift_receiver_sync_edge.sv | 32 +++
 rtl/seg_shift_receiver.sv | 80 ++++++++
 tb/tb_seg_shift_receiver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_link_pkg.sv
// seg_link_pkg: shared constants, frame layout and receiver state encoding for the serial segment link
package seg_link_pkg;
  localparam int SEG_WIDTH = 16;
  localparam int SEG_DIGITS = 8;
  localparam int SEL_LSB = 0;
  localparam int SEG_LSB = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
  } seg_frame_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFTING, ST_LATCH, ST_DECODE} rx_state_t;
endpackage

// File: rtl/seg_shift_receiver_sync_edge.sv
// sync_edge: multi-flop synchroniser with registered rising-edge detect
//   clk, rst_n : system clock, async active-low reset
//   i_d        : asynchronous input line
//   sync       : synchronised level, aligned with rise
//   rise       : one-cycle pulse on each synchronised low-to-high transition
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic sync,
  output logic rise
);
  logic [STAGES-1:0] r_chain;
  logic r_prev;
  logic r_rise;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_chain <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev <= r_chain[STAGES-1];
      r_rise <= r_chain[STAGES-1] & ~r_prev;
    end
  // level is taken from the prev flop so every instance presents data one
  // cycle behind its chain, exactly in step with its registered rise
  assign sync = r_prev;
  assign rise = r_rise;
endmodule

// File: rtl/seg_shift_receiver.sv
// seg_shift_receiver: 74HC595-pair model that deserialises, latches and decodes display frames
//   clk, rst_n             : system clock, async active-low reset
//   seg_sck/seg_din/seg_rck: asynchronous serial link (shift clock, data, latch clock)
//   word, word_valid       : last latched frame and its one-cycle update pulse
//   frame_err              : pulse with word_valid when bit count != WIDTH
//   dsel_err               : pulse one cycle after word_valid for a bad digit select
//   digit_seg, digit_upd   : per-digit segment shadow and per-slot write pulses
module seg_shift_receiver
  import seg_link_pkg::*;
#(
  parameter int WIDTH = SEG_WIDTH,
  parameter int DIGITS = SEG_DIGITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seg_sck,
  input  logic                seg_din,
  input  logic                seg_rck,
  output logic [WIDTH-1:0]    word,
  output logic                word_valid,
  output logic                frame_err,
  output logic                dsel_err,
  output logic [DIGITS*8-1:0] digit_seg,
  output logic [DIGITS-1:0]   digit_upd
);
  logic w_sck_rise, w_rck_rise, w_din;
  logic [WIDTH-1:0] r_sreg, r_word, w_sreg_nx;
  logic [4:0] r_bitcnt, w_cnt_nx;
  logic r_word_valid, r_frame_err, r_dsel_err;
  logic [DIGITS*8-1:0] r_digit_seg;
  logic [DIGITS-1:0] r_digit_upd, w_sel_n, w_dec_upd;
  logic [7:0] w_seg;
  logic w_onehot, w_idle, w_decode;
  rx_state_t r_state;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clk, .rst_n, .i_d(seg_sck), .sync(), .rise(w_sck_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_din (.clk, .rst_n, .i_d(seg_din), .sync(w_din), .rise());
  sync_edge #(.STAGES(SYNC_STAGES)) u_rck (.clk, .rst_n, .i_d(seg_rck), .sync(), .rise(w_rck_rise));
  // shift is resolved before the latch so a coincident rck captures the new bit
  assign w_sreg_nx = w_sck_rise ? {r_sreg[WIDTH-2:0], w_din} : r_sreg;
  assign w_cnt_nx = (w_sck_rise && r_bitcnt != 5'd31) ? r_bitcnt + 5'd1 : r_bitcnt;
  assign w_seg = r_word[SEG_LSB +: 8];
  assign w_sel_n = ~r_word[SEL_LSB +: DIGITS];
  assign w_onehot = $onehot(w_sel_n);
  assign w_idle = w_seg == SEG_OFF && w_sel_n == '0;
  assign w_decode = r_state == ST_LATCH;
  assign w_dec_upd = (w_decode && w_onehot) ? w_sel_n : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sreg <= '0;
      r_bitcnt <= '0;
      r_word <= '0;
      r_word_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_dsel_err <= 1'b0;
      r_digit_upd <= '0;
      r_digit_seg <= {DIGITS{SEG_OFF}};
      r_state <= ST_IDLE;
    end else begin
      r_sreg <= w_sreg_nx;
      r_bitcnt <= w_rck_rise ? '0 : w_cnt_nx;
      r_word_valid <= w_rck_rise;
      r_frame_err <= w_rck_rise && w_cnt_nx != 5'(WIDTH);
      if (w_rck_rise) r_word <= w_sreg_nx;
      r_digit_upd <= w_dec_upd;
      r_dsel_err <= w_decode && !w_onehot && !w_idle;
      for (int k = 0; k < DIGITS; k++)
        if (w_dec_upd[k]) r_digit_seg[8*k +: 8] <= w_seg;
      r_state <= w_rck_rise ? ST_LATCH :
                 r_state == ST_LATCH ? ST_DECODE :
                 r_state == ST_DECODE ? ST_IDLE :
                 w_cnt_nx != '0 ? ST_SHIFTING : ST_IDLE;
    end
  assign word = r_word;
  assign word_valid = r_word_valid;
  assign frame_err = r_frame_err;
  assign dsel_err = r_dsel_err;
  assign digit_seg = r_digit_seg;
  assign digit_upd = r_digit_upd;
endmodule

// File: tb/tb_seg_shift_receiver.sv
// tb_seg_shift_receiver: directed bench with a frame-level reference model checked every cycle
module tb_seg_shift_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic seg_sck = 1'b0;
  logic seg_din = 1'b0;
  logic seg_rck = 1'b0;
  logic [15:0] word;
  logic word_valid, frame_err, dsel_err;
  logic [63:0] digit_seg;
  logic [7:0] digit_upd;

  seg_shift_receiver dut (
    .clk(clk), .rst_n(rst_n), .seg_sck(seg_sck), .seg_din(seg_din), .seg_rck(seg_rck),
    .word(word), .word_valid(word_valid), .frame_err(frame_err), .dsel_err(dsel_err),
    .digit_seg(digit_seg), .digit_upd(digit_upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int due;
    logic [15:0] w;
    bit fe;
  } ev_t;
  ev_t pend[$];
  bit bitq[$];
  int m_cnt = 0;
  int dec_due = -1;
  logic [15:0] exp_word = '0;
  logic [7:0] exp_dig [8];

  int last_vc = -10;
  logic last_fe = 1'b0;
  logic last_ds = 1'b0;
  logic [7:0] last_upd = '0;
  int n_pulse = 0;
  int rck_cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    bitq.delete();
    pend.delete();
    m_cnt = 0;
    dec_due = -1;
    exp_word = '0;
    for (int i = 0; i < 8; i++) exp_dig[i] = 8'hFF;
  endtask

  task automatic m_shift(bit b);
    bitq.push_back(b);
    m_cnt++;
  endtask

  // latched word is the last 16 bits ever shifted since reset (zeros before that)
  task automatic m_latch();
    logic [15:0] w;
    ev_t e;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (bitq.size() - 1 - i >= 0) w[i] = bitq[bitq.size() - 1 - i];
    e.due = cyc + 4;
    e.w = w;
    e.fe = (m_cnt != 16);
    pend.push_back(e);
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    logic e_v, e_fe, e_ds;
    logic [7:0] e_upd;
    logic [63:0] e_dig;
    int nz, pos;
    e_v = 0; e_fe = 0; e_ds = 0; e_upd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_v = 1;
      e_fe = pend[0].fe;
      exp_word = pend[0].w;
      pend.pop_front();
      dec_due = cyc + 1;
    end else if (dec_due == cyc) begin
      nz = 0; pos = 0;
      for (int i = 0; i < 8; i++)
        if (!exp_word[i]) begin nz++; pos = i; end
      if (nz == 1) begin
        e_upd[pos] = 1'b1;
        exp_dig[pos] = exp_word[15:8];
      end else e_ds = (exp_word != 16'hFFFF);
    end
    for (int i = 0; i < 8; i++) e_dig[8*i +: 8] = exp_dig[i];
    chk("word", {48'd0, word}, {48'd0, exp_word});
    chk("word_valid", {63'd0, word_valid}, {63'd0, e_v});
    chk("frame_err", {63'd0, frame_err}, {63'd0, e_fe});
    chk("dsel_err", {63'd0, dsel_err}, {63'd0, e_ds});
    chk("digit_upd", {56'd0, digit_upd}, {56'd0, e_upd});
    chk("digit_seg", digit_seg, e_dig);
    if (word_valid) begin last_vc = cyc; last_fe = frame_err; end
    if (cyc == last_vc + 1) begin last_ds = dsel_err; last_upd = digit_upd; end
    if (word_valid || frame_err || dsel_err || digit_upd != 0) n_pulse++;
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_bits(logic [31:0] v, int n, bit last_rck);
    for (int i = n - 1; i >= 0; i--) begin
      seg_din = v[i];
      tick(4);
      seg_sck = 1'b1;
      m_shift(v[i]);
      if (i == 0 && last_rck) begin
        seg_rck = 1'b1;
        rck_cyc = cyc;
        m_latch();
      end
      tick(4);
      seg_sck = 1'b0;
      seg_rck = 1'b0;
    end
  endtask

  task automatic latch();
    tick(4);
    seg_rck = 1'b1;
    rck_cyc = cyc;
    m_latch();
    tick(4);
    seg_rck = 1'b0;
    tick(4);
  endtask

  task automatic frame(logic [15:0] v);
    send_bits({16'd0, v}, 16, 1'b0);
    latch();
  endtask

  logic [7:0] scan_seg [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

  initial begin
    m_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seg_sck = i[0];
      seg_din = i[1];
      seg_rck = i[2];
    end
    seg_sck = 0; seg_din = 0; seg_rck = 0;
    tick(4);
    chk("reset_digits", digit_seg, {8{8'hFF}});
    rst_n = 1'b1;
    n_pulse = 0;
    tick(20);
    chk("idle_pulses", n_pulse, 0);

    frame(16'hC0FE);
    chk("single_word", {48'd0, word}, 64'h0000_0000_0000_C0FE);
    chk("single_latency", last_vc, rck_cyc + 4);
    chk("single_fe", {63'd0, last_fe}, 0);
    chk("single_upd", {56'd0, last_upd}, 8'h01);
    chk("single_seg0", {56'd0, digit_seg[7:0]}, 8'hC0);

    for (int d = 0; d < 8; d++) frame({scan_seg[d], ~(8'd1 << d)});
    chk("scan_digits", digit_seg, 64'h80F8_8292_99B0_A4F9);
    chk("scan_upd", {56'd0, last_upd}, 8'h80);

    send_bits(32'd0, 15, 1'b0);
    latch();
    chk("short_word", {48'd0, word}, 64'h8000);
    chk("short_fe", {63'd0, last_fe}, 1);
    send_bits(32'hABCDE, 20, 1'b0);
    latch();
    chk("long_word", {48'd0, word}, 64'hBCDE);
    chk("long_fe", {63'd0, last_fe}, 1);

    frame(16'h99FC);
    chk("twosel_ds", {63'd0, last_ds}, 1);
    chk("twosel_digits", digit_seg, 64'h80F8_8292_99B0_A4F9);
    frame(16'hFFFF);
    chk("idle_ds", {63'd0, last_ds}, 0);
    chk("idle_upd", {56'd0, last_upd}, 0);

    send_bits(32'h82FB, 16, 1'b1);
    tick(8);
    chk("simul_word", {48'd0, word}, 64'h82FB);
    chk("simul_fe", {63'd0, last_fe}, 0);
    chk("simul_latency", last_vc, rck_cyc + 4);
    chk("simul_seg2", {56'd0, digit_seg[23:16]}, 8'h82);

    send_bits(32'hAA, 8, 1'b0);
    rst_n = 1'b0;
    m_reset();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    frame(16'hC07F);
    chk("rstmid_word", {48'd0, word}, 64'hC07F);
    chk("rstmid_fe", {63'd0, last_fe}, 0);
    chk("rstmid_digits", digit_seg, 64'hC0FF_FFFF_FFFF_FFFF);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
